// File: rtl/multdiv_if.sv
// multdiv_if: operand/control/result bundle between decode, the
// multiply/divide unit and writeback.
//   master: drives operands and start pulses, observes results
//   slave : the multdiv unit
interface multdiv_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output data_operandA,
      output data_operandB,
      output ctrl_MULT,
      output ctrl_DIV,
      input  data_result,
      input  data_exception,
      input  data_resultRDY,
      input  busy
   );

   modport slave (
      input  data_operandA,
      input  data_operandB,
      input  ctrl_MULT,
      input  ctrl_DIV,
      output data_result,
      output data_exception,
      output data_resultRDY,
      output busy
   );
endinterface

// File: rtl/multdiv.sv
// multdiv: multi-cycle signed multiply (Booth) / divide (restoring).
// Ports: clock, reset (async, active-high), bus (multdiv_if.slave).
// Macro MULTDIV_RADIX4_EN selects radix-4 Booth multiply.
module multdiv #(
   parameter int WIDTH = 32
) (
   input logic      clock,
   input logic      reset,
   multdiv_if.slave bus
);
   localparam int W  = WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
`ifdef MULTDIV_RADIX4_EN
   localparam int MUL_ITERS = WIDTH / 2;
`else
   localparam int MUL_ITERS = WIDTH;
`endif
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
   localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state_q, state_d;

   logic [2*W:0]  prod_q;
   logic [W-1:0]  mcand_q;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  dvs_q;
   logic          qneg_q;
   logic          dz_q;
   logic          ovf_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  result_q;
   logic          exc_q;

   logic start_mul, start_div, start;
   logic [W-1:0] a, b, a_mag, b_mag;

   assign a         = bus.data_operandA;
   assign b         = bus.data_operandB;
   assign start_mul = bus.ctrl_MULT;
   assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
   assign start     = start_mul | start_div;
   assign a_mag     = a[W-1] ? -a : a;
   assign b_mag     = b[W-1] ? -b : b;

   // Booth step. The accumulator is sign-extended before the add so
   // that subtracting the most-negative multiplicand cannot overflow.
   logic [2*W:0] mul_next;
`ifdef MULTDIV_RADIX4_EN
   logic [W+1:0] acc_x, m1, m2, msum;
   always_comb begin
      acc_x = {{2{prod_q[2*W]}}, prod_q[2*W:W+1]};
      m1    = {{2{mcand_q[W-1]}}, mcand_q};
      m2    = {mcand_q[W-1], mcand_q, 1'b0};
      msum  = acc_x;
      case (prod_q[2:0])
         3'b001, 3'b010: msum = acc_x + m1;
         3'b011:         msum = acc_x + m2;
         3'b100:         msum = acc_x - m2;
         3'b101, 3'b110: msum = acc_x - m1;
         default:        msum = acc_x;
      endcase
      mul_next = {msum, prod_q[W:2]};
   end
`else
   logic [W:0] acc_x, m1, msum;
   always_comb begin
      acc_x = {prod_q[2*W], prod_q[2*W:W+1]};
      m1    = {mcand_q[W-1], mcand_q};
      msum  = acc_x;
      case (prod_q[1:0])
         2'b01:   msum = acc_x + m1;
         2'b10:   msum = acc_x - m1;
         default: msum = acc_x;
      endcase
      mul_next = {msum, prod_q[W:1]};
   end
`endif

   // Restoring divide step on magnitudes.
   logic [W:0]   shifted, diff;
   logic [W-1:0] rem_nx, quo_nx;
   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      diff    = shifted - {1'b0, dvs_q};
      rem_nx  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      quo_nx  = {quo_q[W-2:0], ~diff[W]};
   end

   // Product bits [2N-1:N-1] live at prod_q[2N:N].
   logic [W-1:0] mul_res, div_res, quo_s;
   logic         mul_exc, div_exc;
   always_comb begin
      mul_res = prod_q[W:1];
      mul_exc = ~((&prod_q[2*W:W]) | ~(|prod_q[2*W:W]));
      quo_s   = qneg_q ? -quo_q : quo_q;
      div_res = dz_q ? '0 : quo_s;
      div_exc = dz_q | ovf_q;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = start_mul ? MUL : DIV;
      end else begin
         case (state_q)
            MUL:     if (cnt_q == MUL_LAST) state_d = DONE;
            DIV:     if (cnt_q == DIV_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prod_q   <= '0;
         mcand_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else if (start) begin
         prod_q  <= {{W{1'b0}}, b, 1'b0};
         mcand_q <= a;
         rem_q   <= '0;
         quo_q   <= a_mag;
         dvs_q   <= b_mag;
         qneg_q  <= a[W-1] ^ b[W-1];
         dz_q    <= (b == '0);
         ovf_q   <= (a == MOST_NEG) && (&b);
         cnt_q   <= '0;
      end else begin
         case (state_q)
            MUL: begin
               if (cnt_q != MUL_LAST) begin
                  prod_q <= mul_next;
                  cnt_q  <= cnt_q + 1'b1;
               end else begin
                  result_q <= mul_res;
                  exc_q    <= mul_exc;
               end
            end
            DIV: begin
               if (cnt_q != DIV_LAST) begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  result_q <= div_res;
                  exc_q    <= div_exc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = (state_q == DONE);
   assign bus.busy           = (state_q == MUL) || (state_q == DIV);
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: scoreboard bench for multdiv.
// Stimulus pushes expected results; a negedge monitor pops on RDY.
module tb_multdiv;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   multdiv_if #(.WIDTH(32)) bus ();
   multdiv #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

`ifdef MULTDIV_RADIX4_EN
   localparam int LAT_MUL = 17;
`else
   localparam int LAT_MUL = 33;
`endif
   localparam int LAT_DIV = 33;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          at_cyc;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_miss = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (bus.data_resultRDY === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_rdy: got rdy at cyc %0d want none",
                     cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_res"}, bus.data_result, e.res);
            chk({e.tag, "_exc"}, 32'(bus.data_exception), 32'(e.exc));
            chk({e.tag, "_cyc"}, 32'(cyc), 32'(e.at_cyc));
            chk({e.tag, "_busy"}, 32'(bus.busy), 32'd0);
         end
      end
   end

   task automatic issue(input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] r,
                        input logic e, input string tag);
      @(negedge clock);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      if (push)
         sb.push_back('{r, e, cyc + 1 + (m ? LAT_MUL : LAT_DIV), tag});
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
      if (sb.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL timeout: got %0d pending want 0", sb.size());
         sb.delete();
      end
      @(negedge clock);
   endtask

   initial begin
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_res", bus.data_result, 32'd0);
      chk("rst_exc", 32'(bus.data_exception), 32'd0);
      chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;

      issue(1, 0, 32'd7, -32'sd6, 1, 32'hFFFFFFD6, 0, "mul_7x-6");
      drain();
      issue(1, 0, 32'h7FFFFFFF, 32'd17, 1, 32'h7FFFFFEF, 1, "mul_ovf1");
      drain();
      issue(1, 0, 32'h00010000, 32'h00008000, 1, 32'h80000000, 1,
            "mul_ovf2");
      drain();
      issue(0, 1, -32'sd17, 32'd5, 1, 32'hFFFFFFFD, 0, "div_-17/5");
      drain();
      issue(0, 1, 32'd100, 32'd0, 1, 32'd0, 1, "div_by0");
      drain();
      issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1,
            "div_ovf");
      drain();

      issue(0, 1, 32'd100, 32'd7, 0, 32'd0, 0, "div_abort");
      repeat (8) @(negedge clock);
      issue(1, 0, 32'd3, 32'd4, 1, 32'd12, 0, "mul_restart");
      drain();

      issue(1, 1, 32'd6, 32'd3, 1, 32'd18, 0, "mul_div_both");
      drain();

      issue(1, 0, 32'd5, 32'd5, 1, 32'd25, 0, "mul_5x5");
      drain();
      issue(0, 1, 32'd9, 32'd3, 0, 32'd0, 0, "div_reset");
      repeat (11) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("arst_res", bus.data_result, 32'd0);
      chk("arst_exc", 32'(bus.data_exception), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_rdy", 32'(bus.data_resultRDY), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      chk("post_rst_res", bus.data_result, 32'd0);

      issue(1, 0, 32'd9, 32'd9, 1, 32'd81, 0, "mul_9x9");
      bus.data_operandA = 32'hDEADBEEF;
      bus.data_operandB = 32'hFFFFFFFF;
      drain();
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("hold_81", bus.data_result, 32'd81);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/multdiv.md
Name: multdiv

Overview:
- Multi-cycle signed multiply/divide unit in the execute stage, alongside the combinational alu.
- Consumes the same decoded operands (data_operandA/B) that feed the alu, on start pulses from decode.
- Produces a 32-bit result plus an exception flag. Writeback muxes its result against the alu data_result when data_resultRDY fires.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 4. Iteration count N = WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; returns block to IDLE
- data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
- data_operandB  input  WIDTH  multiplier / divisor (two's complement)
- ctrl_MULT  input  1  start-multiply pulse, sampled at rising edge
- ctrl_DIV  input  1  start-divide pulse, sampled at rising edge
- data_result  output  WIDTH  registered result, held until next completion
- data_exception  output  1  registered overflow / divide-by-zero flag, held with data_result
- data_resultRDY  output  1  one-cycle completion strobe
- busy  output  1  high while an operation is in flight

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous, active-high.
- Reset values: state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, busy=0, all internal registers 0.
- States: IDLE, MUL, DIV, DONE.
- Start:
  - At edge S, if ctrl_MULT=1 or ctrl_DIV=1, A and B are captured and the counter is cleared.
  - Next state is MUL or DIV. busy=1 from edge S.
  - If both pulses are high, MULT wins and DIV is ignored.
- Restart: a start pulse in any state (MUL, DIV, DONE) aborts the current operation and restarts with the new operands. No RDY is produced for the aborted operation.
- Iteration: one iteration per edge, S+1 through S+N.
- Completion:
  - At edge S+N+1: state=DONE, data_result/data_exception update, data_resultRDY=1, busy=0.
  - At the next edge: RDY=0 and state=IDLE, unless a new start is present.
  - Latency is N+1 cycles (33 at default).
- Outputs hold: data_result and data_exception keep their value between completions, including through aborts.
- Multiply:
  - Radix-2 Booth over a 2N+1-bit product register; signed x signed.
  - data_result = low N bits of the 2N-bit product.
  - data_exception=1 iff product bits [2N-1:N-1] are not all equal (result not representable).
- Divide:
  - Restoring division on magnitudes; the quotient sign is A[N-1] xor B[N-1]; truncation toward zero.
  - The remainder is discarded.
  - B=0: data_result=0, data_exception=1, same latency.
  - A=most-negative, B=-1: data_result=most-negative (0x80000000), data_exception=1.
  - Otherwise exception=0.
- Reset mid-operation: immediate IDLE. No RDY. Result and exception clear to 0.
- Operands: changes to data_operandA/B after edge S have no effect.

Optional Feature:
- Macro: MULTDIV_RADIX4_EN.
- Defined:
  - Multiply uses modified Booth radix-4, examining 3 bits per step with digits {-2,-1,0,+1,+2}.
  - N/2 iterations; multiply completion at edge S+N/2+1 (17 cycles at default).
  - Results and exceptions are identical to radix-2. Divide is unchanged.
- Undefined: radix-2 multiply, N+1 latency, as above.

Test Plan:
- Reset, then MULT pulse with A=7, B=-6 -> busy high; RDY exactly one cycle at S+33 (S+17 with MULTDIV_RADIX4_EN); result=0xFFFFFFD6 (-42), exception=0.
- MULT A=0x7FFFFFFF, B=17 -> result=0x7FFFFFEF, exception=1. MULT A=0x00010000, B=0x00008000 -> result=0x80000000, exception=1.
- DIV A=-17, B=5 -> result=-3 (0xFFFFFFFD), exception=0. DIV A=100, B=0 -> result=0, exception=1 at S+33. DIV A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Start DIV 100/7, then at S+10 pulse MULT 3*4 -> no RDY for the divide; single RDY at S+10+33 (or S+10+17 with MULTDIV_RADIX4_EN) with result=12. Same-cycle MULT+DIV with A=6, B=3 -> result=18.
- MULT 5*5 completes (result=25), then reset asserted at S'+12 of DIV 9/3 -> outputs 0 immediately and asynchronously; no RDY after reset release.
- Operands changed at S+1 during MULT 9*9 -> result=81; data_result holds 81 for 10 idle cycles after RDY.
